// File: rtl/stroke_endpoint_capture.sv
// Pen-driven line endpoint capture: debounced pen button, stroke FSM and a shadow
// register set that is copied to the display outputs only at frame start.
module stroke_endpoint_capture #(
    parameter int H_ACTIVE        = 1280,
    parameter int V_ACTIVE        = 720,
    parameter int DEBOUNCE_CYCLES = 65535,
    parameter int MIN_LEN         = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] centroid_x_in,
    input  logic [9:0]  centroid_y_in,
    input  logic        centroid_valid_in,
    input  logic        pen_down_in,
    input  logic        clear_in,
    input  logic        new_frame_in,
    output logic [10:0] x_out_1,
    output logic [9:0]  y_out_1,
    output logic [10:0] x_out_2,
    output logic [9:0]  y_out_2,
    output logic        line_valid_out,
    output logic        stroke_done_out,
    output logic [1:0]  state_out
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [10:0]       X_MAX    = 11'(H_ACTIVE - 1);
    localparam logic [9:0]        Y_MAX    = 10'(V_ACTIVE - 1);
    localparam logic [11:0]       LEN_MIN  = 12'(MIN_LEN);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_DRAWING = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    function automatic logic [10:0] clamp_x(input logic [10:0] x);
        return (x > X_MAX) ? X_MAX : x;
    endfunction

    function automatic logic [9:0] clamp_y(input logic [9:0] y);
        return (y > Y_MAX) ? Y_MAX : y;
    endfunction

    // |dx| + |dy| never exceeds 2047 + 1023, so 12 bits cannot overflow.
    function automatic logic [11:0] l1_dist(input logic [10:0] xa, input logic [9:0] ya,
                                            input logic [10:0] xb, input logic [9:0] yb);
        logic signed [11:0] dx;
        logic signed [10:0] dy;
        logic        [11:0] adx;
        logic        [10:0] ady;
        dx  = $signed({1'b0, xb}) - $signed({1'b0, xa});
        dy  = $signed({1'b0, yb}) - $signed({1'b0, ya});
        adx = dx[11] ? 12'(-dx) : 12'(dx);
        ady = dy[10] ? 11'(-dy) : 11'(dy);
        return adx + {1'b0, ady};
    endfunction

    logic              sync1_r, sync2_r, pen_deb_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              pen_flip_s, pen_rise_s, pen_fall_s;

    state_t            state_r, state_nx_s;
    logic [10:0]       start_x_r, end_x_r, cx_s, end_x_upd_s;
    logic [9:0]        start_y_r, end_y_r, cy_s, end_y_upd_s;
    logic              shadow_valid_r, shadow_valid_nx_s;
    logic              capture_s, update_s, done_nx_s, done_r;
    logic [11:0]       len_s;

    // Pen synchroniser and stability counter feeding the debounced level.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            pen_deb_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            sync1_r <= pen_down_in;
            sync2_r <= sync1_r;
            if (sync2_r == pen_deb_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                cnt_r     <= '0;
                pen_deb_r <= sync2_r;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    // Edge pulses coincide with the debounced flip, plus clamped and updated endpoint views.
    always_comb begin
        pen_flip_s  = (sync2_r != pen_deb_r) && (cnt_r == CNT_LAST);
        pen_rise_s  = pen_flip_s && sync2_r;
        pen_fall_s  = pen_flip_s && !sync2_r;
        cx_s        = clamp_x(centroid_x_in);
        cy_s        = clamp_y(centroid_y_in);
        end_x_upd_s = centroid_valid_in ? cx_s : end_x_r;
        end_y_upd_s = centroid_valid_in ? cy_s : end_y_r;
        len_s       = l1_dist(start_x_r, start_y_r, end_x_upd_s, end_y_upd_s);
    end

    // Stroke FSM next-state and shadow-control decode; clear overrides everything.
    always_comb begin
        state_nx_s        = state_r;
        capture_s         = 1'b0;
        update_s          = 1'b0;
        shadow_valid_nx_s = shadow_valid_r;
        done_nx_s         = 1'b0;
        if (clear_in) begin
            state_nx_s        = ST_IDLE;
            shadow_valid_nx_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pen_rise_s) state_nx_s = ST_ARMED;
                    else            state_nx_s = ST_IDLE;
                end
                ST_ARMED: begin
                    if (centroid_valid_in) begin
                        capture_s         = 1'b1;
                        shadow_valid_nx_s = 1'b0;
                        // A release on the capture cycle is a zero-length stroke: discard it.
                        if (pen_fall_s) state_nx_s = ST_IDLE;
                        else            state_nx_s = ST_DRAWING;
                    end else if (pen_fall_s) begin
                        state_nx_s = shadow_valid_r ? ST_HOLD : ST_IDLE;
                    end else begin
                        state_nx_s = ST_ARMED;
                    end
                end
                ST_DRAWING: begin
                    update_s = centroid_valid_in;
                    if (centroid_valid_in) shadow_valid_nx_s = 1'b1;
                    else                   shadow_valid_nx_s = shadow_valid_r;
                    if (pen_fall_s) begin
                        if (len_s >= LEN_MIN) begin
                            state_nx_s = ST_HOLD;
                            done_nx_s  = 1'b1;
                        end else begin
                            state_nx_s        = ST_IDLE;
                            shadow_valid_nx_s = 1'b0;
                        end
                    end else begin
                        state_nx_s = ST_DRAWING;
                    end
                end
                ST_HOLD: begin
                    if (pen_rise_s) state_nx_s = ST_ARMED;
                    else            state_nx_s = ST_HOLD;
                end
                default: begin
                    state_nx_s        = ST_IDLE;
                    shadow_valid_nx_s = 1'b0;
                end
            endcase
        end
    end

    // FSM state, shadow endpoints and stroke-done pulse.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r        <= ST_IDLE;
            start_x_r      <= 11'd0;
            start_y_r      <= 10'd0;
            end_x_r        <= 11'd0;
            end_y_r        <= 10'd0;
            shadow_valid_r <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            shadow_valid_r <= shadow_valid_nx_s;
            done_r         <= done_nx_s;
            if (capture_s) begin
                start_x_r <= cx_s;
                start_y_r <= cy_s;
                end_x_r   <= cx_s;
                end_y_r   <= cy_s;
            end else if (update_s) begin
                end_x_r <= cx_s;
                end_y_r <= cy_s;
            end
        end
    end

    // Display copy at frame start; takes the shadow as it stood before this cycle's update.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            x_out_1        <= 11'd0;
            y_out_1        <= 10'd0;
            x_out_2        <= 11'd0;
            y_out_2        <= 10'd0;
            line_valid_out <= 1'b0;
        end else if (new_frame_in) begin
            x_out_1        <= start_x_r;
            y_out_1        <= start_y_r;
            x_out_2        <= end_x_r;
            y_out_2        <= end_y_r;
            line_valid_out <= shadow_valid_r;
        end
    end

    assign stroke_done_out = done_r;
    assign state_out       = state_r;

endmodule

// File: tb/tb_stroke_endpoint_capture.sv
// Directed bench for stroke_endpoint_capture with DEBOUNCE_CYCLES=4 and MIN_LEN=8.
module tb_stroke_endpoint_capture;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] centroid_x_in;
    logic [9:0]  centroid_y_in;
    logic        centroid_valid_in;
    logic        pen_down_in;
    logic        clear_in;
    logic        new_frame_in;
    logic [10:0] x_out_1, x_out_2;
    logic [9:0]  y_out_1, y_out_2;
    logic        line_valid_out;
    logic        stroke_done_out;
    logic [1:0]  state_out;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    stroke_endpoint_capture #(
        .H_ACTIVE(1280), .V_ACTIVE(720), .DEBOUNCE_CYCLES(4), .MIN_LEN(8)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .centroid_x_in(centroid_x_in), .centroid_y_in(centroid_y_in),
        .centroid_valid_in(centroid_valid_in), .pen_down_in(pen_down_in),
        .clear_in(clear_in), .new_frame_in(new_frame_in),
        .x_out_1(x_out_1), .y_out_1(y_out_1), .x_out_2(x_out_2), .y_out_2(y_out_2),
        .line_valid_out(line_valid_out), .stroke_done_out(stroke_done_out),
        .state_out(state_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (stroke_done_out === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic valid_pt(input int x, input int y);
        centroid_x_in     = 11'(x);
        centroid_y_in     = 10'(y);
        centroid_valid_in = 1'b1;
        step(1);
        centroid_valid_in = 1'b0;
    endtask

    task automatic frame();
        new_frame_in = 1'b1;
        step(1);
        new_frame_in = 1'b0;
    endtask

    task automatic chk_disp(input string tag, input int x1, input int y1,
                            input int x2, input int y2, input int lv);
        chk({tag, ".x1"}, 32'(x_out_1), 32'(x1));
        chk({tag, ".y1"}, 32'(y_out_1), 32'(y1));
        chk({tag, ".x2"}, 32'(x_out_2), 32'(x2));
        chk({tag, ".y2"}, 32'(y_out_2), 32'(y2));
        chk({tag, ".lv"}, 32'(line_valid_out), 32'(lv));
    endtask

    initial begin
        rst_in = 1'b0; centroid_x_in = 11'd0; centroid_y_in = 10'd0;
        centroid_valid_in = 1'b0; pen_down_in = 1'b0; clear_in = 1'b0; new_frame_in = 1'b0;
        step(3);
        chk_disp("reset", 0, 0, 0, 0, 0);
        chk("reset.state", 32'(state_out), 32'd0);
        chk("reset.done", 32'(stroke_done_out), 32'd0);
        rst_in = 1'b1;
        step(1);

        // 1: glitch rejected, then a stable press arms after exactly 6 cycles
        pen_down_in = 1'b1; step(2); pen_down_in = 1'b0; step(8);
        chk("glitch.state", 32'(state_out), 32'd0);
        pen_down_in = 1'b1; step(5);
        chk("deb5.state", 32'(state_out), 32'd0);
        step(1);
        chk("deb6.state", 32'(state_out), 32'd1);

        // 2: long stroke kept
        valid_pt(100, 50);
        chk("s2.drawing", 32'(state_out), 32'd2);
        valid_pt(300, 200);
        pen_down_in = 1'b0; step(5);
        chk("s2.pre_fall", 32'(state_out), 32'd2);
        step(1);
        chk("s2.hold", 32'(state_out), 32'd3);
        chk("s2.done_hi", 32'(stroke_done_out), 32'd1);
        step(1);
        chk("s2.done_lo", 32'(stroke_done_out), 32'd0);
        chk("s2.no_frame_lv", 32'(line_valid_out), 32'd0);
        frame();
        chk_disp("s2.disp", 100, 50, 300, 200, 1);
        chk("s2.done_cnt", 32'(done_cnt), 32'd1);

        // 3: short stroke discarded (L1 = 5)
        pen_down_in = 1'b1; step(6);
        chk("s3.armed", 32'(state_out), 32'd1);
        chk("s3.old_line", 32'(line_valid_out), 32'd1);
        valid_pt(100, 50);
        valid_pt(103, 52);
        pen_down_in = 1'b0; step(6);
        chk("s3.idle", 32'(state_out), 32'd0);
        chk("s3.no_done", 32'(stroke_done_out), 32'd0);
        frame();
        chk("s3.lv", 32'(line_valid_out), 32'd0);
        chk("s3.done_cnt", 32'(done_cnt), 32'd1);

        // 4: tearing, then release with simultaneous valid at exactly MIN_LEN
        pen_down_in = 1'b1; step(6);
        chk("s4.armed", 32'(state_out), 32'd1);
        valid_pt(10, 10);
        valid_pt(15, 13);
        frame();
        chk_disp("s4.disp1", 10, 10, 15, 13, 1);
        centroid_x_in = 11'd400; centroid_y_in = 10'd400;
        centroid_valid_in = 1'b1; new_frame_in = 1'b1;
        step(1);
        centroid_valid_in = 1'b0; new_frame_in = 1'b0;
        chk("s4.tear_x2", 32'(x_out_2), 32'd15);
        chk("s4.tear_y2", 32'(y_out_2), 32'd13);
        frame();
        chk("s4.next_x2", 32'(x_out_2), 32'd400);
        chk("s4.next_y2", 32'(y_out_2), 32'd400);
        valid_pt(11, 11);
        pen_down_in = 1'b0; step(5);
        centroid_x_in = 11'd15; centroid_y_in = 10'd13; centroid_valid_in = 1'b1;
        step(1);
        centroid_valid_in = 1'b0;
        chk("s4.hold", 32'(state_out), 32'd3);
        chk("s4.done", 32'(stroke_done_out), 32'd1);
        frame();
        chk_disp("s4.disp2", 10, 10, 15, 13, 1);
        chk("s4.done_cnt", 32'(done_cnt), 32'd2);

        // 5: release in ARMED returns to HOLD; clamping; clear during DRAWING
        pen_down_in = 1'b1; step(6);
        chk("s5.armed", 32'(state_out), 32'd1);
        pen_down_in = 1'b0; step(6);
        chk("s5.back_hold", 32'(state_out), 32'd3);
        chk("s5.no_done", 32'(stroke_done_out), 32'd0);
        pen_down_in = 1'b1; step(6);
        valid_pt(5, 5);
        valid_pt(2047, 1023);
        frame();
        chk_disp("s5.clamp", 5, 5, 1279, 719, 1);
        valid_pt(1279, 718);
        frame();
        chk("s5.edge_x2", 32'(x_out_2), 32'd1279);
        chk("s5.edge_y2", 32'(y_out_2), 32'd718);
        valid_pt(1280, 720);
        frame();
        chk("s5.at_lim_x2", 32'(x_out_2), 32'd1279);
        chk("s5.at_lim_y2", 32'(y_out_2), 32'd719);
        clear_in = 1'b1; step(1); clear_in = 1'b0;
        chk("s5.clear_idle", 32'(state_out), 32'd0);
        chk("s5.clear_lv_held", 32'(line_valid_out), 32'd1);
        frame();
        chk("s5.clear_lv", 32'(line_valid_out), 32'd0);
        pen_down_in = 1'b0; step(8);
        chk("s5.release_idle", 32'(state_out), 32'd0);
        chk("s5.done_cnt", 32'(done_cnt), 32'd2);

        // 6: async reset mid-stroke, then a normal stroke afterwards
        pen_down_in = 1'b1; step(6);
        valid_pt(20, 20);
        valid_pt(200, 200);
        frame();
        chk("s6.pre_x2", 32'(x_out_2), 32'd200);
        chk("s6.pre_state", 32'(state_out), 32'd2);
        rst_in = 1'b0; pen_down_in = 1'b0;
        #1;
        chk_disp("s6.rst", 0, 0, 0, 0, 0);
        chk("s6.rst_state", 32'(state_out), 32'd0);
        step(2);
        rst_in = 1'b1;
        step(1);
        pen_down_in = 1'b1; step(6);
        chk("s6.armed", 32'(state_out), 32'd1);
        valid_pt(30, 40);
        valid_pt(130, 90);
        pen_down_in = 1'b0; step(6);
        chk("s6.hold", 32'(state_out), 32'd3);
        chk("s6.done", 32'(stroke_done_out), 32'd1);
        frame();
        chk_disp("s6.disp", 30, 40, 130, 90, 1);
        chk("s6.done_cnt", 32'(done_cnt), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
